// File: rtl/argmax_stream_if.sv
// Stream bundle for argmax_stream: score input channel plus the top-2 result channel.
interface argmax_stream_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_W     = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
  logic [WORD_SIZE-1:0] out_val;
  logic [IDX_W-1:0]     out_idx2;
  logic [WORD_SIZE-1:0] out_val2;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_val, out_idx2, out_val2
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_val, out_idx2, out_val2
  );
endinterface

// File: rtl/argmax_stream.sv
// Serial top-2 arg-max over a frame of LAYER_SIZE scores, one score per valid/ready transfer.
module argmax_stream #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LAYER_SIZE = 10,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  argmax_stream_if.slave bus,
  output logic [15:0] frame_cnt
);
  localparam int unsigned IDX_W = $clog2(LAYER_SIZE);

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     best_idx;
  logic [WORD_SIZE-1:0] best_val;
  logic [IDX_W-1:0]     sec_idx;
  logic [WORD_SIZE-1:0] sec_val;
  logic                 sec_empty;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last_elem;

  function automatic logic gt(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_fire   = bus.in_valid & bus.in_ready;
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign last_elem = (cnt == IDX_W'(LAYER_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (in_fire && last_elem) state_nxt = S_OUT;
      S_OUT:   if (out_fire)             state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_ACC:   bus.in_ready  = 1'b1;
      S_OUT:   bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b1;
    endcase
  end

  // Fold one score into the running top-2; ties keep the earlier index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      sec_idx   <= '0;
      sec_val   <= '0;
      sec_empty <= 1'b1;
    end else if (in_fire) begin
      cnt <= last_elem ? '0 : cnt + IDX_W'(1);
      if (cnt == '0) begin
        best_idx  <= '0;
        best_val  <= bus.in_data;
        sec_empty <= 1'b1;
      end else if (gt(bus.in_data, best_val)) begin
        sec_idx   <= best_idx;
        sec_val   <= best_val;
        sec_empty <= 1'b0;
        best_idx  <= cnt;
        best_val  <= bus.in_data;
      end else if (sec_empty || gt(bus.in_data, sec_val)) begin
        sec_idx   <= cnt;
        sec_val   <= bus.in_data;
        sec_empty <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           frame_cnt <= '0;
    else if (out_fire) frame_cnt <= frame_cnt + 16'd1;
  end

  // Fold registers only change in S_ACC, so they are stable whenever out_valid is high.
  assign bus.out_idx  = best_idx;
  assign bus.out_val  = best_val;
  assign bus.out_idx2 = sec_idx;
  assign bus.out_val2 = sec_val;
endmodule
